// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of byte-enabled stores between the store
// datapath and the data-memory write port. It also provides per-byte
// store-to-load forwarding from the entries it is holding.

// One forwarding lane. The inputs are ordered by age, with index 0 the
// oldest entry. The youngest entry that supplies this byte wins.
module store_buffer_lane #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      hit,
  input  logic [DEPTH-1:0][7:0] byte_in,
  output logic [7:0]            byte_out,
  output logic                  be_out
);
  // Scan from oldest to youngest so that later (younger) hits override
  always_comb begin
    byte_out = '0;
    be_out   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit[k]) begin
        byte_out = byte_in[k];
        be_out   = 1'b1;
      end
    end
  end
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_be,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      ld_addr,
  output logic [31:0]      ld_fwd_data,
  output logic [3:0]       ld_fwd_be,
  output logic             ld_fwd_full,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH-1:0][29:0]  ent_addr;
  logic [DEPTH-1:0][31:0]  ent_data;
  logic [DEPTH-1:0][3:0]   ent_be;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    enq, deq;

  // A store with an all-zero byte enable completes its handshake but is
  // not written into the buffer
  assign st_ready      = (cnt < CNT_W'(DEPTH));
  assign empty         = (cnt == '0);
  assign count         = cnt;
  assign mem_req_valid = !empty;
  assign enq           = st_valid && st_ready && (st_be != 4'b0000);
  assign deq           = mem_req_valid && mem_req_ready;

  // The head entry drives the memory port; the outputs are zero when the buffer is empty
  assign mem_addr  = empty ? 32'h0 : {ent_addr[rd_ptr], 2'b00};
  assign mem_wdata = empty ? 32'h0 : ent_data[rd_ptr];
  assign mem_be    = empty ? 4'h0  : ent_be[rd_ptr];

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld  <= '0;
      ent_addr <= '0;
      ent_data <= '0;
      ent_be   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (enq) begin
        ent_vld[wr_ptr]  <= 1'b1;
        ent_addr[wr_ptr] <= st_addr[31:2];
        ent_data[wr_ptr] <= st_data;
        ent_be[wr_ptr]   <= st_be;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      // No enqueue can occur when the buffer is full, and no dequeue can
      // occur when it is empty. So a dequeue and an enqueue in the same
      // cycle never target the same slot.
      if (deq) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Reorder the entries by age, counting from the read pointer, so that
  // wrap-around never affects which entry is youngest
  logic [DEPTH-1:0]           age_match;
  logic [DEPTH-1:0][3:0]      age_be;
  logic [DEPTH-1:0][31:0]     age_data;
  logic [3:0][DEPTH-1:0]      lane_hit;
  logic [3:0][DEPTH-1:0][7:0] lane_byte;

  genvar k, i;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_age
      logic [AW-1:0] idx;
      assign idx          = rd_ptr + AW'(k);
      assign age_match[k] = ent_vld[idx] && (ent_addr[idx] == ld_addr[31:2]);
      assign age_be[k]    = ent_be[idx];
      assign age_data[k]  = ent_data[idx];
      for (i = 0; i < 4; i++) begin : g_lane_in
        assign lane_hit[i][k]  = age_match[k] && age_be[k][i];
        assign lane_byte[i][k] = age_data[k][8*i +: 8];
      end
    end

    for (i = 0; i < 4; i++) begin : g_lane
      store_buffer_lane #(.DEPTH(DEPTH)) u_lane (
        .hit      (lane_hit[i]),
        .byte_in  (lane_byte[i]),
        .byte_out (ld_fwd_data[8*i +: 8]),
        .be_out   (ld_fwd_be[i])
      );
    end
  endgenerate

  assign ld_fwd_full = (ld_fwd_be == 4'b1111);
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer. A queue-based reference model is compared with
// the DUT on every falling edge. Directed scenarios add hand-computed
// literal checks, covering memory write order and forwarding results.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             st_valid = 1'b0;
  logic             st_ready;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_data = '0;
  logic [3:0]       st_be = '0;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      ld_addr = '0;
  logic [31:0]      ld_fwd_data;
  logic [3:0]       ld_fwd_be;
  logic             ld_fwd_full;
  logic [CNT_W-1:0] count;
  logic             empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_be(st_be),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_be(ld_fwd_be),
    .ld_fwd_full(ld_fwd_full), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending stores
  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else begin
      bit do_deq, do_enq;
      ent_t e;
      do_deq = (q.size() > 0) && mem_req_ready;
      do_enq = st_valid && (q.size() < DEPTH) && (st_be != 4'b0000);
      e.a = st_addr[31:2]; e.d = st_data; e.be = st_be;
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(e);
    end
  end

  // Observed memory writes, for checking order against literals
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_be[$];

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] fd;
    logic [3:0]  fb;
    fd = '0; fb = '0;
    foreach (q[j]) begin
      if (q[j].a == ld_addr[31:2]) begin
        for (int l = 0; l < 4; l++) begin
          if (q[j].be[l]) begin
            fd[8*l +: 8] = q[j].d[8*l +: 8];
            fb[l] = 1'b1;
          end
        end
      end
    end
    chk("st_ready", st_ready, (q.size() < DEPTH));
    chk("count", count, q.size());
    chk("empty", empty, (q.size() == 0));
    chk("mem_req_valid", mem_req_valid, (q.size() != 0));
    chk("mem_addr", mem_addr, (q.size() != 0) ? {q[0].a, 2'b00} : 32'h0);
    chk("mem_wdata", mem_wdata, (q.size() != 0) ? q[0].d : 32'h0);
    chk("mem_be", mem_be, (q.size() != 0) ? q[0].be : 4'h0);
    chk("ld_fwd_data", ld_fwd_data, fd);
    chk("ld_fwd_be", ld_fwd_be, fb);
    chk("ld_fwd_full", ld_fwd_full, (fb == 4'hF));
    if (!rst && mem_req_valid && mem_req_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_be.push_back(mem_be);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
    tick();
    st_valid = 1'b0;
  endtask

  localparam logic [31:0] T1_DATA [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

  initial begin
    int base;
    ld_addr = 32'h104;
    tick(); tick();
    chk("reset_st_ready", st_ready, 1);
    chk("reset_mem_req_valid", mem_req_valid, 0);
    chk("reset_empty", empty, 1);
    rst = 1'b0;
    tick();

    // Fill the buffer to capacity while memory is stalled
    mem_req_ready = 1'b0;
    for (int n = 0; n < 4; n++) put(32'h100 + 32'(4*n), T1_DATA[n], 4'hF);
    chk("full_count", count, 4);
    chk("full_st_ready", st_ready, 0);
    st_valid = 1'b1; st_addr = 32'h110; st_data = 32'hDEADBEEF; st_be = 4'hF;
    tick();
    chk("stall_mem_addr0", mem_addr, 32'h100);
    tick();
    chk("stall_count", count, 4);
    chk("stall_mem_addr1", mem_addr, 32'h100);
    st_valid = 1'b0;

    // Drain the buffer
    mem_req_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", empty, 1);
    chk("drain_mem_req_valid", mem_req_valid, 0);
    for (int n = 0; n < 4; n++) begin
      chk("drain_addr", (log_addr.size() > n) ? log_addr[n] : 32'hX, 32'h100 + 32'(4*n));
      chk("drain_data", (log_data.size() > n) ? log_data[n] : 32'hX, T1_DATA[n]);
      chk("drain_be", (log_be.size() > n) ? 32'(log_be[n]) : 32'hX, 32'hF);
    end

    // Enqueue and dequeue together at count 2, wrapping the pointers
    base = log_addr.size();
    mem_req_ready = 1'b0;
    put(32'h400, 32'h00000000, 4'hF);
    put(32'h404, 32'h01010101, 4'hF);
    mem_req_ready = 1'b1;
    for (int n = 2; n < 8; n++) begin
      st_valid = 1'b1; st_addr = 32'h400 + 32'(4*n); st_data = 32'h01010101 * n; st_be = 4'hF;
      tick();
      chk("steady_count", count, 2);
    end
    st_valid = 1'b0;
    repeat (2) tick();
    chk("steady_empty", empty, 1);
    for (int n = 0; n < 8; n++) begin
      chk("steady_order", (log_addr.size() > base + n) ? log_addr[base + n] : 32'hX, 32'h400 + 32'(4*n));
      chk("steady_data", (log_data.size() > base + n) ? log_data[base + n] : 32'hX, 32'h01010101 * n);
    end

    // Forwarding that merges bytes from two entries
    mem_req_ready = 1'b0;
    put(32'h200, 32'hAABBCCDD, 4'b1111);
    put(32'h201, 32'h55555555, 4'b0010);
    ld_addr = 32'h200; #1;
    chk("merge_data", ld_fwd_data, 32'hAABB55DD);
    chk("merge_be", ld_fwd_be, 4'b1111);
    chk("merge_full", ld_fwd_full, 1);
    ld_addr = 32'h204; #1;
    chk("nomatch_be", ld_fwd_be, 4'b0000);
    chk("nomatch_data", ld_fwd_data, 32'h0);
    mem_req_ready = 1'b1;
    repeat (2) tick();

    // Partial forwarding; a store with a zero byte enable must be dropped
    mem_req_ready = 1'b0;
    put(32'h302, 32'h12341234, 4'b1100);
    put(32'h300, 32'hFFFFFFFF, 4'b0000);
    chk("zero_be_count", count, 1);
    ld_addr = 32'h300; #1;
    chk("partial_be", ld_fwd_be, 4'b1100);
    chk("partial_data", ld_fwd_data, 32'h12340000);
    chk("partial_full", ld_fwd_full, 0);
    mem_req_ready = 1'b1;
    tick();

    // Asynchronous reset with stores still pending
    mem_req_ready = 1'b0;
    put(32'h500, 32'hCAFEF00D, 4'hF);
    put(32'h504, 32'hBEEFBEEF, 4'hF);
    put(32'h508, 32'h0BADF00D, 4'hF);
    chk("prerst_count", count, 3);
    rst = 1'b1; #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick(); tick();
    rst = 1'b0;
    base = log_addr.size();
    mem_req_ready = 1'b1;
    repeat (5) tick();
    chk("rst_no_writes", log_addr.size(), base);
    chk("rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
